// File: rtl/pi_incr_mc.sv
// Multi-channel incremental PI controller: one shared multiplier walks CH channels
// per sample tick, accumulating KA*e(n) - KB*e(n-1) into saturated outputs.
module pi_incr_mc #(
  parameter int CH      = 4,
  parameter int W       = 32,
  parameter int GW      = 16,
  parameter int SH      = 7,
  parameter int DB      = 32,
  parameter int INV_SET = 1,
  parameter logic signed [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}},
  parameter logic signed [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            clr,
  input  logic [CH-1:0]   ch_en,
  input  logic [CH-1:0]   ovr,
  input  logic [CH*W-1:0] set_flat,
  input  logic [CH*W-1:0] fb_flat,
  input  logic [W-1:0]    ovr_val,
  input  logic [GW-1:0]   ka,
  input  logic [GW-1:0]   kb,
  output logic            busy,
  output logic            done,
  output logic [CH*W-1:0] out_flat
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int EW = W + SH + 1;
  localparam int PW = W + GW;
  localparam int SW = W + GW + 2;

  localparam logic signed [EW-1:0] DB_E  = EW'(DB);
  localparam logic signed [EW-1:0] E_MAX = {{(EW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [EW-1:0] E_MIN = {{(EW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [SW-1:0] O_MAX = {{(SW-W){OUT_MAX[W-1]}}, OUT_MAX};
  localparam logic signed [SW-1:0] O_MIN = {{(SW-W){OUT_MIN[W-1]}}, OUT_MIN};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ERR = 3'd1, S_MULA = 3'd2, S_MULB = 3'd3, S_ACC = 3'd4, S_DONE = 3'd5
  } state_t;

  // Deadband first, then saturate the wide error back to W bits.
  function automatic logic signed [W-1:0] err_shape(input logic signed [EW-1:0] x);
    logic signed [W-1:0] r;
    if ((x > -DB_E) && (x < DB_E)) r = '0;
    else if (x > E_MAX)            r = {1'b0, {(W-1){1'b1}}};
    else if (x < E_MIN)            r = {1'b1, {(W-1){1'b0}}};
    else                           r = x[W-1:0];
    return r;
  endfunction

  function automatic logic signed [W-1:0] clamp_out(input logic signed [SW-1:0] x);
    logic signed [W-1:0] r;
    if (x > O_MAX)      r = OUT_MAX;
    else if (x < O_MIN) r = OUT_MIN;
    else                r = x[W-1:0];
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic signed [GW-1:0]  ka_q, ka_d, kb_q, kb_d;
  logic signed [W-1:0]   ovr_val_q, ovr_val_d;
  logic [CH-1:0]         ovr_q, ovr_d, ch_en_q, ch_en_d;
  logic signed [W-1:0]   set_q [CH], set_d [CH], fb_q [CH], fb_d [CH];
  logic signed [W-1:0]   out_q [CH], out_d [CH], prev_q [CH], prev_d [CH];
  logic signed [W-1:0]   e_q, e_d;
  logic signed [PW-1:0]  p_q, p_d, i_q, i_d;

  logic signed [W-1:0]   set_sel, fb_sel, prev_sel, out_sel, e_calc, acc_res;
  logic                  ovr_sel, en_sel;
  logic signed [EW-1:0]  s_ext, e_raw;
  logic signed [PW-1:0]  mul_a, mul_b, prod;
  logic signed [PW:0]    delta;
  logic signed [SW-1:0]  sum;

  // Datapath for the current channel: error shaping, shared multiplier, accumulate.
  always_comb begin
    set_sel  = set_q[ch_q];
    fb_sel   = fb_q[ch_q];
    prev_sel = prev_q[ch_q];
    out_sel  = out_q[ch_q];
    ovr_sel  = ovr_q[ch_q];
    en_sel   = ch_en_q[ch_q];
    s_ext    = {{(EW-W){set_sel[W-1]}}, set_sel};
    if (INV_SET != 0) s_ext = -s_ext;
    else              s_ext = s_ext;
    // A zero set-point means "stopped" and must never be overridden.
    if (ovr_sel && (set_sel != '0)) s_ext = {{(EW-W){ovr_val_q[W-1]}}, ovr_val_q};
    else                            s_ext = s_ext;
    e_raw  = (s_ext <<< SH) - {{(EW-W){fb_sel[W-1]}}, fb_sel};
    e_calc = err_shape(e_raw);
    if (state_q == S_MULB) begin
      mul_a = {{(PW-GW){kb_q[GW-1]}}, kb_q};
      mul_b = {{(PW-W){prev_sel[W-1]}}, prev_sel};
    end else begin
      mul_a = {{(PW-GW){ka_q[GW-1]}}, ka_q};
      mul_b = {{(PW-W){e_q[W-1]}}, e_q};
    end
    prod    = mul_a * mul_b;
    delta   = {p_q[PW-1], p_q} - {i_q[PW-1], i_q};
    sum     = {{(SW-W){out_sel[W-1]}}, out_sel} + {{(SW-PW-1){delta[PW]}}, delta};
    acc_res = clamp_out(sum);
  end

  // Sequencer and next-state values for every flop.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    done_d    = 1'b0;
    ka_d      = ka_q;
    kb_d      = kb_q;
    ovr_val_d = ovr_val_q;
    ovr_d     = ovr_q;
    ch_en_d   = ch_en_q;
    set_d     = set_q;
    fb_d      = fb_q;
    out_d     = out_q;
    prev_d    = prev_q;
    e_d       = e_q;
    p_d       = p_q;
    i_d       = i_q;
    if (clr) begin
      state_d = S_IDLE;
      ch_d    = '0;
      for (int c = 0; c < CH; c++) begin
        out_d[c]  = '0;
        prev_d[c] = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_ERR;
            ch_d      = '0;
            ka_d      = ka;
            kb_d      = kb;
            ovr_val_d = ovr_val;
            ovr_d     = ovr;
            ch_en_d   = ch_en;
            for (int c = 0; c < CH; c++) begin
              set_d[c] = set_flat[c*W +: W];
              fb_d[c]  = fb_flat[c*W +: W];
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ERR: begin
          e_d     = e_calc;
          state_d = S_MULA;
        end
        S_MULA: begin
          p_d     = prod;
          state_d = S_MULB;
        end
        S_MULB: begin
          i_d     = prod;
          state_d = S_ACC;
        end
        S_ACC: begin
          if (en_sel) begin
            out_d[ch_q]  = acc_res;
            prev_d[ch_q] = e_q;
          end else begin
            out_d[ch_q]  = out_q[ch_q];
            prev_d[ch_q] = prev_q[ch_q];
          end
          if (ch_q == CW'(CH - 1)) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + CW'(1);
            state_d = S_ERR;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_ERR) || (state_d == S_MULA) ||
             (state_d == S_MULB) || (state_d == S_ACC);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ka_q      <= '0;
      kb_q      <= '0;
      ovr_val_q <= '0;
      ovr_q     <= '0;
      ch_en_q   <= '0;
      e_q       <= '0;
      p_q       <= '0;
      i_q       <= '0;
      for (int c = 0; c < CH; c++) begin
        set_q[c]  <= '0;
        fb_q[c]   <= '0;
        out_q[c]  <= '0;
        prev_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ka_q      <= ka_d;
      kb_q      <= kb_d;
      ovr_val_q <= ovr_val_d;
      ovr_q     <= ovr_d;
      ch_en_q   <= ch_en_d;
      e_q       <= e_d;
      p_q       <= p_d;
      i_q       <= i_d;
      for (int c = 0; c < CH; c++) begin
        set_q[c]  <= set_d[c];
        fb_q[c]   <= fb_d[c];
        out_q[c]  <= out_d[c];
        prev_q[c] <= prev_d[c];
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Flatten the per-channel accumulators onto the output bus.
  always_comb begin
    out_flat = '0;
    for (int c = 0; c < CH; c++) out_flat[c*W +: W] = out_q[c];
  end

endmodule

// File: tb/tb_pi_incr_mc.sv
// Scoreboard bench for pi_incr_mc: a default-clamp instance and a +/-100000 clamp
// instance share stimulus; an integer model predicts both output buses per tick.
module tb_pi_incr_mc;
  localparam int CH = 4;
  localparam int W  = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr = 1'b0;
  logic [CH-1:0] ch_en = '0, ovr = '0;
  logic signed [W-1:0] set_a [CH];
  logic signed [W-1:0] fb_a [CH];
  logic [CH*W-1:0] set_flat, fb_flat;
  logic signed [W-1:0] ovr_val = '0;
  logic signed [15:0] ka = 16'sd360, kb = 16'sd210;
  logic busy1, done1, busy2, done2;
  logic [CH*W-1:0] out1, out2;

  int checks = 0, passed = 0, failed = 0;
  logic [CH*W-1:0] q1 [$];
  logic [CH*W-1:0] q2 [$];
  longint m_out1 [CH], m_out2 [CH], m_prev [CH];

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      set_flat[c*W +: W] = set_a[c];
      fb_flat[c*W +: W]  = fb_a[c];
    end
  end

  pi_incr_mc u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .ch_en(ch_en), .ovr(ovr),
    .set_flat(set_flat), .fb_flat(fb_flat), .ovr_val(ovr_val), .ka(ka), .kb(kb),
    .busy(busy1), .done(done1), .out_flat(out1)
  );

  pi_incr_mc #(.OUT_MAX(32'sd100000), .OUT_MIN(-32'sd100000)) u_dut_clamp (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .ch_en(ch_en), .ovr(ovr),
    .set_flat(set_flat), .fb_flat(fb_flat), .ovr_val(ovr_val), .ka(ka), .kb(kb),
    .busy(busy2), .done(done2), .out_flat(out2)
  );

  task automatic chk(input string tag, input logic [CH*W-1:0] obs, input logic [CH*W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint clampl(input longint x, input longint lo, input longint hi);
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_out1[c] = 0;
      m_out2[c] = 0;
      m_prev[c] = 0;
    end
  endtask

  // Predict one full tick with plain integer arithmetic and queue the results.
  task automatic model_tick();
    logic [CH*W-1:0] f1, f2;
    longint s, e, d;
    for (int c = 0; c < CH; c++) begin
      if (ch_en[c]) begin
        s = -longint'(set_a[c]);
        if (ovr[c] && set_a[c] != 0) s = longint'(ovr_val);
        e = s * 128 - longint'(fb_a[c]);
        if (e > -32 && e < 32) e = 0;
        e = clampl(e, -64'sd2147483648, 64'sd2147483647);
        d = longint'(ka) * e - longint'(kb) * m_prev[c];
        m_out1[c] = clampl(m_out1[c] + d, -64'sd2147483648, 64'sd2147483647);
        m_out2[c] = clampl(m_out2[c] + d, -64'sd100000, 64'sd100000);
        m_prev[c] = e;
      end
      f1[c*W +: W] = m_out1[c][W-1:0];
      f2[c*W +: W] = m_out2[c][W-1:0];
    end
    q1.push_back(f1);
    q2.push_back(f2);
  endtask

  task automatic wait_no_done(input int ncyc, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (done1 || done2) seen = 1'b1;
    end
    chk(tag, {127'b0, seen}, '0);
  endtask

  // One sample tick: start pulse, bounded wait for done, latency and scoreboard compare.
  task automatic run_tick(input string tag, input bit extra_start);
    int n;
    logic got;
    logic [CH*W-1:0] e1, e2;
    model_tick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (extra_start && n == 5) start = 1'b1;
      else start = 1'b0;
      if (n == 1) chk({tag, "_busy"}, {127'b0, busy1}, {127'b0, 1'b1});
      if (done1) got = 1'b1;
    end
    chk({tag, "_latency"}, 128'(n), 128'(17));
    chk({tag, "_done2"}, {127'b0, done2}, {127'b0, got});
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    chk({tag, "_out"}, out1, e1);
    chk({tag, "_outclamp"}, out2, e2);
    @(negedge clk);
    chk({tag, "_idle"}, {126'b0, busy1, done1}, '0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    chk("clr_out", out1 | out2, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < CH; c++) begin
      set_a[c] = '0;
      fb_a[c]  = '0;
    end
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_out", out1 | out2, '0);
      chk("rst_busy_done", {124'b0, busy1, done1, busy2, done2}, '0);
    end

    // Basic step on ch0, then a second tick uses the stored previous error.
    ch_en = 4'b0001;
    set_a[0] = -32'sd2;
    run_tick("t2a", 1'b0);
    chk32("t2a_out0", out1[31:0], 32'sd92160);
    run_tick("t2b", 1'b0);
    chk32("t2b_out0", out1[31:0], 32'sd130560);
    chk32("t4_clamp_hi", out2[31:0], 32'sd100000);

    // Deadband edges on ch1.
    do_clr();
    set_a[0] = '0;
    ch_en = 4'b0010;
    fb_a[1] = 32'sd31;
    run_tick("t3a", 1'b0);
    fb_a[1] = 32'sd32;
    run_tick("t3b", 1'b0);
    chk32("t3b_out1", out1[63:32], -32'sd11520);

    // Negative mirror of the clamp test.
    do_clr();
    fb_a[1] = '0;
    ch_en = 4'b0001;
    set_a[0] = 32'sd2;
    run_tick("t4a", 1'b0);
    run_tick("t4b", 1'b0);
    chk32("t4_clamp_lo", out2[31:0], -32'sd100000);

    // Override on ch2, then zero set-point disables it.
    do_clr();
    set_a[0] = '0;
    ch_en = 4'b0100;
    ovr = 4'b0100;
    ovr_val = -32'sd32;
    set_a[2] = -32'sd5;
    run_tick("t5a", 1'b0);
    chk32("t5a_out2", out1[95:64], -32'sd1474560);
    do_clr();
    set_a[2] = '0;
    run_tick("t5b", 1'b0);
    ovr = '0;
    ovr_val = '0;

    // All channels with mixed random set-points and feedback.
    ch_en = 4'b1011;
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < CH; c++) begin
        set_a[c] = 32'($urandom_range(2000)) - 32'd1000;
        fb_a[c]  = 32'($urandom_range(400000)) - 32'd200000;
      end
      ovr = 4'($urandom_range(15));
      ovr_val = 32'($urandom_range(600)) - 32'd300;
      run_tick("rand", 1'b0);
    end

    // start while busy is ignored: one done only.
    run_tick("t6busy", 1'b1);
    wait_no_done(20, "t6_single_done");

    // clr during MULB of ch1 aborts the sequence.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    chk("t6_clr_busy", {127'b0, busy1}, '0);
    chk("t6_clr_out", out1 | out2, '0);
    wait_no_done(30, "t6_clr_no_done");

    // clr wins over a simultaneous start.
    @(negedge clk);
    clr = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    start = 1'b0;
    chk("t6_clrstart_busy", {127'b0, busy1}, '0);
    wait_no_done(25, "t6_clrstart_no_done");

    // Accumulation still works after the aborts.
    ch_en = 4'b1111;
    run_tick("post", 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
